// File: rtl/dp_ram_pkg.sv
// Shared defaults and word/address types for the dual-port RAM.
package dp_ram_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 4;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
endpackage

// File: rtl/dp_ram_array.sv
// Storage array with asynchronous clear, a synchronous write port and a
// combinational lookup that feeds the registered read port in the top.
module dp_ram_array #(
  parameter int DATA_WIDTH = dp_ram_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = dp_ram_pkg::ADDR_WIDTH,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_word
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Whole array clears on reset so unwritten words never read as X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= w_data;
    end
  end

  assign rd_word = mem[rd_addr];

endmodule

// File: rtl/dp_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port,
// write-first when both ports hit the same address in the same cycle.
module dp_ram #(
  parameter int DATA_WIDTH = dp_ram_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = dp_ram_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rd_word;
  logic                  collide;

  dp_ram_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .w_data (w_data),
    .rd_addr(rd_addr),
    .rd_word(rd_word)
  );

  assign collide = wr_en && (wr_addr == rd_addr);

  // r_data holds across idle cycles; only rst returns it to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (rd_en) begin
      r_data <= collide ? w_data : rd_word;
    end
  end

endmodule

// File: tb/tb_dp_ram.sv
// Self-checking bench for dp_ram: directed vector table, hand-written reset
// sequences and a randomized run against an array-based reference model.
module tb_dp_ram;
  import dp_ram_pkg::*;

  logic  clk;
  logic  rst;
  logic  wr_en;
  logic  rd_en;
  addr_t wr_addr;
  addr_t rd_addr;
  data_t w_data;
  data_t r_data;

  int errors;
  int checks;

  data_t m_mem [16];
  data_t m_r;

  typedef struct {
    logic  we;
    logic  re;
    addr_t wa;
    addr_t ra;
    data_t wd;
    data_t exp;
  } vec_t;

  vec_t tbl[$];

  dp_ram u_dut (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .wr_addr(wr_addr),
    .rd_addr(rd_addr),
    .w_data (w_data),
    .r_data (r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input data_t act, input data_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic re, input int wa,
                              input int ra, input int wd, input int exp);
    vec_t v;
    v.we  = we;
    v.re  = re;
    v.wa  = addr_t'(wa);
    v.ra  = addr_t'(ra);
    v.wd  = data_t'(wd);
    v.exp = data_t'(exp);
    return v;
  endfunction

  // One clock: drive just after an edge, let the next edge take it, then
  // update the model from the RAM's rules and leave the bus idle.
  task automatic step(input logic we, input logic re, input addr_t wa,
                      input addr_t ra, input data_t wd);
    wr_en   = we;
    rd_en   = re;
    wr_addr = wa;
    rd_addr = ra;
    w_data  = wd;
    @(posedge clk);
    #1;
    if (!rst) begin
      if (re) m_r = (we && wa == ra) ? wd : m_mem[ra];
      if (we) m_mem[wa] = wd;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_r = '0;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst     = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_addr = '0;
    rd_addr = '0;
    w_data  = '0;
    model_clear();

    // Reset held three cycles, with a write attempt that must be discarded.
    wr_en   = 1'b1;
    wr_addr = 4'd1;
    w_data  = 8'hEE;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", r_data, 8'h00);
    rst   = 1'b0;
    wr_en = 1'b0;

    for (int a = 0; a < 16; a++) begin
      step(1'b0, 1'b1, '0, addr_t'(a), '0);
      check($sformatf("reset_read_a%0d", a), r_data, 8'h00);
    end

    tbl.push_back(mk(1, 0,  3, 0, 'hA5, 'h00));
    tbl.push_back(mk(0, 1,  0, 3, 'h00, 'hA5));
    tbl.push_back(mk(1, 0,  7, 0, 'h11, 'hA5));
    tbl.push_back(mk(0, 1,  0, 7, 'h00, 'h11));
    tbl.push_back(mk(1, 1,  7, 7, 'h22, 'h22));
    tbl.push_back(mk(0, 1,  0, 7, 'h00, 'h22));
    tbl.push_back(mk(1, 0,  9, 0, 'h99, 'h22));
    tbl.push_back(mk(1, 1,  2, 9, 'h3C, 'h99));
    tbl.push_back(mk(0, 1,  0, 2, 'h00, 'h3C));
    tbl.push_back(mk(0, 0,  2, 2, 'hFF, 'h3C));
    tbl.push_back(mk(0, 0,  9, 9, 'h00, 'h3C));
    tbl.push_back(mk(1, 0,  5, 5, 'h5A, 'h3C));
    tbl.push_back(mk(0, 0, 15, 0, 'hC3, 'h3C));
    tbl.push_back(mk(0, 0,  0, 15, 'h81, 'h3C));
    tbl.push_back(mk(1, 0,  0, 0, 'hE1, 'h3C));
    tbl.push_back(mk(1, 1, 15, 0, 'h1E, 'hE1));
    tbl.push_back(mk(0, 1,  0, 15, 'h00, 'h1E));
    tbl.push_back(mk(0, 1,  0, 5, 'h00, 'h5A));

    foreach (tbl[i]) begin
      step(tbl[i].we, tbl[i].re, tbl[i].wa, tbl[i].ra, tbl[i].wd);
      check($sformatf("vec%0d", i), r_data, tbl[i].exp);
    end

    // Full sweep: data = addr ^ 0x5A everywhere, then read back in order.
    for (int a = 0; a < 16; a++) step(1'b1, 1'b0, addr_t'(a), '0, data_t'(a ^ 'h5A));
    for (int a = 0; a < 16; a++) begin
      step(1'b0, 1'b1, '0, addr_t'(a), '0);
      check($sformatf("sweep_a%0d", a), r_data, data_t'(a ^ 'h5A));
    end
    check("sweep_a15_const", r_data, 8'h55);

    // Reset asserted between edges clears r_data immediately.
    step(1'b1, 1'b0, 4'd4, '0, 8'h77);
    step(1'b0, 1'b1, '0, 4'd4, '0);
    check("pre_reset_a4", r_data, 8'h77);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_rdata", r_data, 8'h00);
    wr_en   = 1'b1;
    wr_addr = 4'd6;
    w_data  = 8'hAB;
    rd_en   = 1'b1;
    rd_addr = 4'd4;
    @(posedge clk);
    #1;
    check("reset_cycle_rdata", r_data, 8'h00);
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    model_clear();
    step(1'b0, 1'b1, '0, 4'd6, '0);
    check("post_reset_a6", r_data, 8'h00);
    step(1'b0, 1'b1, '0, 4'd5, '0);
    check("post_reset_a5", r_data, 8'h00);
    step(1'b0, 1'b1, '0, 4'd4, '0);
    check("post_reset_a4", r_data, 8'h00);

    // Randomized traffic; a narrow address window forces frequent collisions.
    for (int n = 0; n < 400; n++) begin
      logic  we, re;
      addr_t wa, ra;
      data_t wd;
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        wa = addr_t'($urandom_range(0, 2));
        ra = addr_t'($urandom_range(0, 2));
      end else begin
        wa = addr_t'($urandom_range(0, 15));
        ra = addr_t'($urandom_range(0, 15));
      end
      wd = data_t'($urandom_range(0, 255));
      step(we, re, wa, ra, wd);
      check($sformatf("rand%0d", n), r_data, m_r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
